// File: rtl/cnt_pkg.sv
// Shared types and default constants for the up/down skip counter and its decoder.
// The counter, this decoder and their benches all take their limits from here.
package cnt_pkg;

  localparam int CNT_W = 10;
  localparam int ERR_W = 8;

  typedef logic signed [CNT_W-1:0] cnt_t;
  // Two guard bits keep p +/- 2*step from overflowing at the range edges.
  typedef logic signed [CNT_W+1:0] cnt_wide_t;

  localparam cnt_t CNT_MIN = cnt_t'(-230);
  localparam cnt_t CNT_MAX = cnt_t'(235);
  localparam cnt_t CNT_INV = cnt_t'(-11);
  localparam cnt_t CNT_UP  = cnt_t'(5);
  localparam cnt_t CNT_DN  = cnt_t'(9);
  localparam cnt_t CNT_RST = cnt_t'(-50);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

  function automatic cnt_wide_t widen(cnt_t v);
    return cnt_wide_t'(v);
  endfunction

  function automatic logic is_legal(cnt_t v);
    return (v != CNT_INV) && (v >= CNT_MIN) && (v <= CNT_MAX);
  endfunction

endpackage

// File: rtl/cnt_step_decoder_if.sv
// Sample stream into the decoder and its registered decode results.
// cnt_valid marks a new sample for one cycle; there is no ready, the decoder accepts every valid sample.
interface cnt_step_decoder_if;
  import cnt_pkg::*;

  logic              cnt_valid;
  cnt_t              cnt;
  logic              locked;
  logic              dir;
  logic              ev_valid;
  logic              ev_skip;
  logic              ev_wrap;
  logic              step_err;
  logic              val_err;
  logic [ERR_W-1:0]  err_cnt;
  state_t            dbg_state;

  modport master (
    output cnt_valid, cnt,
    input  locked, dir, ev_valid, ev_skip, ev_wrap, step_err, val_err, err_cnt, dbg_state
  );

  modport slave (
    input  cnt_valid, cnt,
    output locked, dir, ev_valid, ev_skip, ev_wrap, step_err, val_err, err_cnt, dbg_state
  );

endinterface

// File: rtl/cnt_next_calc.sv
// Combinational next-value calculator: up and down targets from a previous value,
// with flags telling whether each target skipped over INV or wrapped around the range.
module cnt_next_calc
  import cnt_pkg::*;
(
  input  cnt_t i_prev,
  output cnt_t o_up_tgt,
  output logic o_up_skip,
  output logic o_up_wrap,
  output cnt_t o_dn_tgt,
  output logic o_dn_skip,
  output logic o_dn_wrap
);

  cnt_wide_t w_p;
  cnt_wide_t w_up1;
  cnt_wide_t w_up2;
  cnt_wide_t w_dn1;
  cnt_wide_t w_dn2;

  always_comb begin
    w_p   = widen(i_prev);

    // Skip is resolved before wrap, so a skipped target can still wrap.
    w_up1     = w_p + widen(CNT_UP);
    o_up_skip = (w_up1 == widen(CNT_INV));
    w_up2     = o_up_skip ? (w_up1 + widen(CNT_UP)) : w_up1;
    o_up_wrap = (w_up2 > widen(CNT_MAX));
    o_up_tgt  = o_up_wrap ? CNT_MIN : w_up2[CNT_W-1:0];

    w_dn1     = w_p - widen(CNT_DN);
    o_dn_skip = (w_dn1 == widen(CNT_INV));
    w_dn2     = o_dn_skip ? (w_dn1 - widen(CNT_DN)) : w_dn1;
    o_dn_wrap = (w_dn2 < widen(CNT_MIN));
    o_dn_tgt  = o_dn_wrap ? CNT_MAX : w_dn2[CNT_W-1:0];
  end

endmodule

// File: rtl/cnt_step_decoder.sv
// Receive-side decoder for the up/down skip counter: recovers direction, classifies
// each step as normal/skip/wrap, and flags illegal values and steps with a saturating count.
module cnt_step_decoder
  import cnt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cnt_step_decoder_if.slave    bus
);

  state_t           r_state;
  cnt_t             r_prev;
  logic             r_dir;
  logic             r_ev_valid;
  logic             r_ev_skip;
  logic             r_ev_wrap;
  logic             r_step_err;
  logic             r_val_err;
  logic [ERR_W-1:0] r_err_cnt;

  state_t           w_state_nxt;
  cnt_t             w_prev_nxt;
  logic             w_dir_nxt;
  logic             w_ev_valid_nxt;
  logic             w_ev_skip_nxt;
  logic             w_ev_wrap_nxt;
  logic             w_step_err_nxt;
  logic             w_val_err_nxt;
  logic             w_err_inc;
  logic [ERR_W-1:0] w_err_cnt_nxt;

  cnt_t             w_up_tgt;
  cnt_t             w_dn_tgt;
  logic             w_up_skip;
  logic             w_up_wrap;
  logic             w_dn_skip;
  logic             w_dn_wrap;

  cnt_next_calc u_next_calc (
    .i_prev    (r_prev),
    .o_up_tgt  (w_up_tgt),
    .o_up_skip (w_up_skip),
    .o_up_wrap (w_up_wrap),
    .o_dn_tgt  (w_dn_tgt),
    .o_dn_skip (w_dn_skip),
    .o_dn_wrap (w_dn_wrap)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_prev_nxt     = r_prev;
    w_dir_nxt      = r_dir;
    w_ev_valid_nxt = 1'b0;
    w_ev_skip_nxt  = 1'b0;
    w_ev_wrap_nxt  = 1'b0;
    w_step_err_nxt = 1'b0;
    w_val_err_nxt  = 1'b0;
    w_err_inc      = 1'b0;

    if (bus.cnt_valid) begin
      if (!is_legal(bus.cnt)) begin
        // An illegal value drops lock and is not used as a step reference.
        w_val_err_nxt = 1'b1;
        w_err_inc     = 1'b1;
        w_state_nxt   = IDLE;
      end else if (r_state == IDLE) begin
        w_prev_nxt  = bus.cnt;
        w_state_nxt = ACQ;
      end else if (bus.cnt == w_up_tgt) begin
        w_ev_valid_nxt = 1'b1;
        w_ev_skip_nxt  = w_up_skip;
        w_ev_wrap_nxt  = w_up_wrap;
        w_dir_nxt      = 1'b1;
        w_prev_nxt     = bus.cnt;
        w_state_nxt    = TRACK;
      end else if (bus.cnt == w_dn_tgt) begin
        w_ev_valid_nxt = 1'b1;
        w_ev_skip_nxt  = w_dn_skip;
        w_ev_wrap_nxt  = w_dn_wrap;
        w_dir_nxt      = 1'b0;
        w_prev_nxt     = bus.cnt;
        w_state_nxt    = TRACK;
      end else begin
        w_step_err_nxt = 1'b1;
        w_err_inc      = 1'b1;
        w_prev_nxt     = bus.cnt;
        w_state_nxt    = ACQ;
      end
    end

    w_err_cnt_nxt = (w_err_inc && (r_err_cnt != '1)) ? r_err_cnt + 1'b1 : r_err_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prev     <= '0;
      r_dir      <= 1'b1;
      r_ev_valid <= 1'b0;
      r_ev_skip  <= 1'b0;
      r_ev_wrap  <= 1'b0;
      r_step_err <= 1'b0;
      r_val_err  <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_prev_nxt;
      r_dir      <= w_dir_nxt;
      r_ev_valid <= w_ev_valid_nxt;
      r_ev_skip  <= w_ev_skip_nxt;
      r_ev_wrap  <= w_ev_wrap_nxt;
      r_step_err <= w_step_err_nxt;
      r_val_err  <= w_val_err_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  assign bus.locked    = (r_state == TRACK);
  assign bus.dir       = r_dir;
  assign bus.ev_valid  = r_ev_valid;
  assign bus.ev_skip   = r_ev_skip;
  assign bus.ev_wrap   = r_ev_wrap;
  assign bus.step_err  = r_step_err;
  assign bus.val_err   = r_val_err;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_cnt_step_decoder.sv
// Directed bench for cnt_step_decoder; flag vectors are {locked,dir,ev_valid,ev_skip,ev_wrap,step_err,val_err}.
module tb_cnt_step_decoder;
  import cnt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  cnt_step_decoder_if bus ();

  cnt_step_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] flags();
    return {bus.locked, bus.dir, bus.ev_valid, bus.ev_skip, bus.ev_wrap, bus.step_err, bus.val_err};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.cnt_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input int v);
    @(negedge clk);
    bus.cnt_valid = 1'b1;
    bus.cnt       = cnt_t'(v);
    @(posedge clk);
    #1;
    bus.cnt_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (flags() !== 7'b0100000) $display("FAIL reset_flags got=%b exp=%b", flags(), 7'b0100000);
    else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd0) $display("FAIL reset_err got=%0d exp=0", bus.err_cnt);
    else n_pass++;
    n_total++;
    if (bus.dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, IDLE);
    else n_pass++;
  endtask

  task automatic test_up_normal();
    do_reset();
    send(-50);
    n_total++;
    if (flags() !== 7'b0100000) $display("FAIL up_seed got=%b exp=%b", flags(), 7'b0100000);
    else n_pass++;
    send(-45);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL up_step1 got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
    send(-40);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL up_step2 got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
  endtask

  task automatic test_skip_up();
    do_reset();
    send(-21);
    send(-16);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL skip_up_pre got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
    send(-6);
    n_total++;
    if (flags() !== 7'b1111000) $display("FAIL skip_up got=%b exp=%b", flags(), 7'b1111000);
    else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd0) $display("FAIL skip_up_err got=%0d exp=0", bus.err_cnt);
    else n_pass++;
  endtask

  task automatic test_down_and_wrap();
    do_reset();
    send(7);
    send(-2);
    n_total++;
    if (flags() !== 7'b1010000) $display("FAIL dn_step got=%b exp=%b", flags(), 7'b1010000);
    else n_pass++;
    send(-20);
    n_total++;
    if (flags() !== 7'b1011000) $display("FAIL dn_skip got=%b exp=%b", flags(), 7'b1011000);
    else n_pass++;
    send(232);
    n_total++;
    if (flags() !== 7'b0000010) $display("FAIL dn_jump_err got=%b exp=%b", flags(), 7'b0000010);
    else n_pass++;
    send(-230);
    n_total++;
    if (flags() !== 7'b1110100) $display("FAIL up_wrap got=%b exp=%b", flags(), 7'b1110100);
    else n_pass++;
    send(-226);
    n_total++;
    if (flags() !== 7'b0100010) $display("FAIL wrap_gap_err got=%b exp=%b", flags(), 7'b0100010);
    else n_pass++;
    send(235);
    n_total++;
    if (flags() !== 7'b1010100) $display("FAIL dn_wrap got=%b exp=%b", flags(), 7'b1010100);
    else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd2) $display("FAIL wrap_err_cnt got=%0d exp=2", bus.err_cnt);
    else n_pass++;
  endtask

  task automatic test_val_err();
    do_reset();
    send(0);
    send(5);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL val_lock got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
    send(-11);
    n_total++;
    if (flags() !== 7'b0100001 || bus.err_cnt !== 8'd1)
      $display("FAIL val_inv got=%b/%0d exp=%b/1", flags(), bus.err_cnt, 7'b0100001);
    else n_pass++;
    send(300);
    n_total++;
    if (flags() !== 7'b0100001 || bus.err_cnt !== 8'd2)
      $display("FAIL val_big got=%b/%0d exp=%b/2", flags(), bus.err_cnt, 7'b0100001);
    else n_pass++;
    send(10);
    n_total++;
    if (flags() !== 7'b0100000 || bus.err_cnt !== 8'd2)
      $display("FAIL val_reseed got=%b/%0d exp=%b/2", flags(), bus.err_cnt, 7'b0100000);
    else n_pass++;
    send(15);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL val_relock got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
    send(-231);
    n_total++;
    if (flags() !== 7'b0100001 || bus.err_cnt !== 8'd3)
      $display("FAIL val_below_min got=%b/%0d exp=%b/3", flags(), bus.err_cnt, 7'b0100001);
    else n_pass++;
    send(236);
    n_total++;
    if (flags() !== 7'b0100001 || bus.err_cnt !== 8'd4)
      $display("FAIL val_above_max got=%b/%0d exp=%b/4", flags(), bus.err_cnt, 7'b0100001);
    else n_pass++;
    send(-230);
    n_total++;
    if (flags() !== 7'b0100000) $display("FAIL val_min_legal got=%b exp=%b", flags(), 7'b0100000);
    else n_pass++;
    send(235);
    n_total++;
    if (flags() !== 7'b1010100) $display("FAIL val_max_legal got=%b exp=%b", flags(), 7'b1010100);
    else n_pass++;
  endtask

  task automatic test_step_err();
    do_reset();
    send(100);
    send(105);
    send(107);
    n_total++;
    if (flags() !== 7'b0100010 || bus.err_cnt !== 8'd1)
      $display("FAIL step_bad got=%b/%0d exp=%b/1", flags(), bus.err_cnt, 7'b0100010);
    else n_pass++;
    send(112);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL step_relock got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
    send(112);
    n_total++;
    if (flags() !== 7'b0100010 || bus.err_cnt !== 8'd2)
      $display("FAIL step_hold got=%b/%0d exp=%b/2", flags(), bus.err_cnt, 7'b0100010);
    else n_pass++;
    send(117);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL step_after_hold got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send((i % 2 == 0) ? 300 : -231);
      if (i == 254) begin
        n_total++;
        if (bus.err_cnt !== 8'd255) $display("FAIL sat_reach got=%0d exp=255", bus.err_cnt);
        else n_pass++;
      end
    end
    n_total++;
    if (bus.err_cnt !== 8'd255 || flags() !== 7'b0100001)
      $display("FAIL sat_hold got=%0d/%b exp=255/%b", bus.err_cnt, flags(), 7'b0100001);
    else n_pass++;
    send(0);
    n_total++;
    if (bus.err_cnt !== 8'd255 || flags() !== 7'b0100000)
      $display("FAIL sat_legal got=%0d/%b exp=255/%b", bus.err_cnt, flags(), 7'b0100000);
    else n_pass++;
  endtask

  task automatic test_reset_during_track();
    do_reset();
    send(300);
    send(20);
    send(11);
    n_total++;
    if (flags() !== 7'b1010000 || bus.err_cnt !== 8'd1)
      $display("FAIL rst_pre got=%b/%0d exp=%b/1", flags(), bus.err_cnt, 7'b1010000);
    else n_pass++;
    @(negedge clk);
    rst           = 1'b1;
    bus.cnt_valid = 1'b1;
    bus.cnt       = cnt_t'(2);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.cnt_valid = 1'b0;
    n_total++;
    if (flags() !== 7'b0100000 || bus.err_cnt !== 8'd0 || bus.dbg_state !== IDLE)
      $display("FAIL rst_track got=%b/%0d/%0d exp=%b/0/%0d", flags(), bus.err_cnt, bus.dbg_state, 7'b0100000, IDLE);
    else n_pass++;
    send(2);
    n_total++;
    if (flags() !== 7'b0100000) $display("FAIL rst_reseed got=%b exp=%b", flags(), 7'b0100000);
    else n_pass++;
    send(7);
    n_total++;
    if (flags() !== 7'b1110000) $display("FAIL rst_relock got=%b exp=%b", flags(), 7'b1110000);
    else n_pass++;
  endtask

  initial begin
    bus.cnt_valid = 1'b0;
    bus.cnt       = '0;
    test_reset();
    test_up_normal();
    test_skip_up();
    test_down_and_wrap();
    test_val_err();
    test_step_err();
    test_saturation();
    test_reset_during_track();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
